// File: rtl/ats21_cmd_capture.sv
// ATS21 command capture: two-beat half-word capture, per-client FIFOs, round-robin issue.
// Optional reserved-opcode filter enabled by defining ATS21_OPCODE_FILTER_EN.
module ats21_cmd_capture #(
    parameter int FIFO_DEPTH = 4,
    parameter int INST_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [15:0]       ctrlA,
    input  logic [15:0]       ctrlB,
    output logic              inst_valid,
    output logic [INST_W-1:0] inst_data,
    output logic              inst_client,
    input  logic              inst_ready,
    output logic              busy,
    output logic              ovf_a,
    output logic              ovf_b,
    output logic              illegal
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {
        S_IDLE,
        S_LOW
    } state_e;

    state_e state_q, state_d;

    logic [15:0] hi_a_q, hi_a_d;
    logic [15:0] hi_b_q, hi_b_d;
    logic        act_a_q, act_a_d;
    logic        act_b_q, act_b_d;

    logic [INST_W-1:0] mem_a_q [FIFO_DEPTH];
    logic [INST_W-1:0] mem_a_d [FIFO_DEPTH];
    logic [INST_W-1:0] mem_b_q [FIFO_DEPTH];
    logic [INST_W-1:0] mem_b_d [FIFO_DEPTH];

    logic [PW-1:0] wp_a_q, wp_a_d;
    logic [PW-1:0] rp_a_q, rp_a_d;
    logic [PW-1:0] wp_b_q, wp_b_d;
    logic [PW-1:0] rp_b_q, rp_b_d;

    logic rr_q, rr_d;
    logic ovf_a_q, ovf_a_d;
    logic ovf_b_q, ovf_b_d;

    logic [INST_W-1:0] last_data_q, last_data_d;
    logic              last_client_q, last_client_d;

    logic              in_low;
    logic              empty_a, empty_b;
    logic              full_a, full_b;
    logic              sel_b;
    logic              accept;
    logic              pop_a, pop_b;
    logic              want_a, want_b;
    logic              push_a, push_b;
    logic              rsv_a, rsv_b;
    logic [INST_W-1:0] word_a, word_b;
    logic [INST_W-1:0] head;

    assign in_low = (state_q == S_LOW);
    assign word_a = {hi_a_q, ctrlA};
    assign word_b = {hi_b_q, ctrlB};

    assign empty_a = (wp_a_q == rp_a_q);
    assign empty_b = (wp_b_q == rp_b_q);
    assign full_a  = (wp_a_q[AW] != rp_a_q[AW]) &&
                     (wp_a_q[AW-1:0] == rp_a_q[AW-1:0]);
    assign full_b  = (wp_b_q[AW] != rp_b_q[AW]) &&
                     (wp_b_q[AW-1:0] == rp_b_q[AW-1:0]);

    // B wins only when A is empty or the pointer favours B
    assign sel_b  = !empty_b && (empty_a || rr_q);
    assign head   = sel_b ? mem_b_q[rp_b_q[AW-1:0]]
                          : mem_a_q[rp_a_q[AW-1:0]];
    assign accept = inst_valid && inst_ready;
    assign pop_a  = accept && !sel_b;
    assign pop_b  = accept && sel_b;

`ifdef ATS21_OPCODE_FILTER_EN
    logic illegal_q, illegal_d;

    assign rsv_a = act_a_q && (hi_a_q[15:13] == 3'b100);
    assign rsv_b = act_b_q && (hi_b_q[15:13] == 3'b100);
    assign illegal_d = illegal_q || (in_low && (rsv_a || rsv_b));
    assign illegal = illegal_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_d;
        end
    end
`else
    assign rsv_a   = 1'b0;
    assign rsv_b   = 1'b0;
    assign illegal = 1'b0;
`endif

    assign want_a = in_low && act_a_q && !rsv_a;
    assign want_b = in_low && act_b_q && !rsv_b;
    // A full FIFO still takes the word if its head leaves on the same edge
    assign push_a = want_a && (!full_a || pop_a);
    assign push_b = want_b && (!full_b || pop_b);

    always_comb begin
        state_d = state_q;
        hi_a_d  = hi_a_q;
        hi_b_d  = hi_b_q;
        act_a_d = act_a_q;
        act_b_d = act_b_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    hi_a_d  = ctrlA;
                    hi_b_d  = ctrlB;
                    act_a_d = (ctrlA[15:13] != 3'b000);
                    act_b_d = (ctrlB[15:13] != 3'b000);
                    if (act_a_d || act_b_d) begin
                        state_d = S_LOW;
                    end
                end
            end
            S_LOW: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        mem_a_d = mem_a_q;
        mem_b_d = mem_b_q;
        wp_a_d  = wp_a_q;
        wp_b_d  = wp_b_q;
        rp_a_d  = rp_a_q;
        rp_b_d  = rp_b_q;
        if (push_a) begin
            mem_a_d[wp_a_q[AW-1:0]] = word_a;
            wp_a_d = wp_a_q + PW'(1);
        end
        if (push_b) begin
            mem_b_d[wp_b_q[AW-1:0]] = word_b;
            wp_b_d = wp_b_q + PW'(1);
        end
        if (pop_a) begin
            rp_a_d = rp_a_q + PW'(1);
        end
        if (pop_b) begin
            rp_b_d = rp_b_q + PW'(1);
        end
    end

    always_comb begin
        rr_d          = rr_q;
        ovf_a_d       = ovf_a_q || (want_a && !push_a);
        ovf_b_d       = ovf_b_q || (want_b && !push_b);
        last_data_d   = last_data_q;
        last_client_d = last_client_q;
        if (accept) begin
            rr_d = !sel_b;
        end
        if (inst_valid) begin
            last_data_d   = head;
            last_client_d = sel_b;
        end
    end

    assign inst_valid  = !empty_a || !empty_b;
    assign inst_data   = inst_valid ? head : last_data_q;
    assign inst_client = inst_valid ? sel_b : last_client_q;
    assign busy        = in_low;
    assign ovf_a       = ovf_a_q;
    assign ovf_b       = ovf_b_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= S_IDLE;
            hi_a_q        <= '0;
            hi_b_q        <= '0;
            act_a_q       <= 1'b0;
            act_b_q       <= 1'b0;
            wp_a_q        <= '0;
            rp_a_q        <= '0;
            wp_b_q        <= '0;
            rp_b_q        <= '0;
            rr_q          <= 1'b0;
            ovf_a_q       <= 1'b0;
            ovf_b_q       <= 1'b0;
            last_data_q   <= '0;
            last_client_q <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_a_q[i] <= '0;
                mem_b_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            hi_a_q        <= hi_a_d;
            hi_b_q        <= hi_b_d;
            act_a_q       <= act_a_d;
            act_b_q       <= act_b_d;
            wp_a_q        <= wp_a_d;
            rp_a_q        <= rp_a_d;
            wp_b_q        <= wp_b_d;
            rp_b_q        <= rp_b_d;
            rr_q          <= rr_d;
            ovf_a_q       <= ovf_a_d;
            ovf_b_q       <= ovf_b_d;
            last_data_q   <= last_data_d;
            last_client_q <= last_client_d;
            mem_a_q       <= mem_a_d;
            mem_b_q       <= mem_b_d;
        end
    end

endmodule

// File: tb/tb_ats21_cmd_capture.sv
// Bench for ats21_cmd_capture: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_ats21_cmd_capture;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        req;
    logic [15:0] ctrlA;
    logic [15:0] ctrlB;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic        inst_client;
    logic        inst_ready;
    logic        busy;
    logic        ovf_a;
    logic        ovf_b;
    logic        illegal;

    int total = 0;
    int bad   = 0;

    ats21_cmd_capture #(.FIFO_DEPTH(DEPTH), .INST_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .ctrlA       (ctrlA),
        .ctrlB       (ctrlB),
        .inst_valid  (inst_valid),
        .inst_data   (inst_data),
        .inst_client (inst_client),
        .inst_ready  (inst_ready),
        .busy        (busy),
        .ovf_a       (ovf_a),
        .ovf_b       (ovf_b),
        .illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model state
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    bit          m_low;
    logic [15:0] m_hi_a, m_hi_b;
    bit          m_act_a, m_act_b;
    bit          m_turn_b;
    bit          m_ovf_a, m_ovf_b, m_ill;
    logic [31:0] m_last;
    bit          m_last_c;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        qa.delete();
        qb.delete();
        m_low    = 0;
        m_act_a  = 0;
        m_act_b  = 0;
        m_turn_b = 0;
        m_ovf_a  = 0;
        m_ovf_b  = 0;
        m_ill    = 0;
        m_last   = '0;
        m_last_c = 0;
    endtask

    function automatic bit m_valid();
        return (qa.size() != 0) || (qb.size() != 0);
    endfunction

    function automatic bit m_selb();
        return (qb.size() != 0) && ((qa.size() == 0) || m_turn_b);
    endfunction

    function automatic logic [31:0] m_head();
        if (!m_valid()) return m_last;
        return m_selb() ? qb[0] : qa[0];
    endfunction

    function automatic bit m_client();
        if (!m_valid()) return m_last_c;
        return m_selb();
    endfunction

    function automatic bit reserved(input logic [31:0] w);
`ifdef ATS21_OPCODE_FILTER_EN
        return w[31:29] == 3'b100;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_push(input bit is_b, input logic [31:0] w);
        if (reserved(w)) begin
            m_ill = 1;
        end else if (!is_b) begin
            if (qa.size() < DEPTH) qa.push_back(w);
            else m_ovf_a = 1;
        end else begin
            if (qb.size() < DEPTH) qb.push_back(w);
            else m_ovf_b = 1;
        end
    endtask

    // what one rising edge does to the model, given the driven inputs
    task automatic model_edge(input bit r, input logic [15:0] a,
                              input logic [15:0] b, input bit rdy);
        bit sb;
        sb = m_selb();
        if (m_valid()) begin
            m_last   = m_head();
            m_last_c = sb;
            if (rdy) begin
                if (sb) void'(qb.pop_front());
                else void'(qa.pop_front());
                m_turn_b = !sb;
            end
        end
        if (m_low) begin
            if (m_act_a) model_push(0, {m_hi_a, a});
            if (m_act_b) model_push(1, {m_hi_b, b});
            m_low = 0;
        end else if (r) begin
            m_hi_a  = a;
            m_hi_b  = b;
            m_act_a = (a[15:13] != 3'b000);
            m_act_b = (b[15:13] != 3'b000);
            m_low   = m_act_a || m_act_b;
        end
    endtask

    task automatic check_all(input string p);
        chk({p, "_valid"}, 32'(inst_valid), 32'(m_valid()));
        chk({p, "_data"}, inst_data, m_head());
        chk({p, "_client"}, 32'(inst_client), 32'(m_client()));
        chk({p, "_busy"}, 32'(busy), 32'(m_low));
        chk({p, "_ovf_a"}, 32'(ovf_a), 32'(m_ovf_a));
        chk({p, "_ovf_b"}, 32'(ovf_b), 32'(m_ovf_b));
        chk({p, "_illegal"}, 32'(illegal), 32'(m_ill));
    endtask

    task automatic step(input bit r, input logic [15:0] a,
                        input logic [15:0] b, input bit rdy);
        req        = r;
        ctrlA      = a;
        ctrlB      = b;
        inst_ready = rdy;
        model_edge(r, a, b, rdy);
        @(posedge clk);
        #1;
        check_all("cyc");
    endtask

    task automatic do_reset();
        req        = 0;
        ctrlA      = '0;
        ctrlB      = '0;
        inst_ready = 0;
        reset      = 0;
        model_reset();
        @(posedge clk);
        #1;
        check_all("rst");
        reset = 1;
    endtask

    logic [31:0] w;

    initial begin
        reset      = 0;
        req        = 0;
        ctrlA      = '0;
        ctrlB      = '0;
        inst_ready = 0;
        model_reset();
        #2;
        chk("por_valid", 32'(inst_valid), 0);
        chk("por_data", inst_data, 0);
        chk("por_busy", 32'(busy), 0);
        do_reset();

        // single A transfer
        step(1, 16'h2200, 16'h0000, 0);
        chk("a1_busy", 32'(busy), 1);
        step(0, 16'h0000, 16'h0000, 0);
        chk("a1_valid", 32'(inst_valid), 1);
        chk("a1_data", inst_data, 32'h2200_0000);
        chk("a1_client", 32'(inst_client), 0);
        step(0, 16'h0000, 16'h0000, 1);
        chk("a1_empty", 32'(inst_valid), 0);

        // dual transfer, A issued before B
        do_reset();
        step(1, 16'hA025, 16'hB700, 1);
        step(0, 16'h0025, 16'h0025, 1);
        chk("d_data0", inst_data, 32'hA025_0025);
        chk("d_cl0", 32'(inst_client), 0);
        step(0, 16'h0000, 16'h0000, 1);
        chk("d_data1", inst_data, 32'hB700_0025);
        chk("d_cl1", 32'(inst_client), 1);
        step(0, 16'h0000, 16'h0000, 1);
        chk("d_empty", 32'(inst_valid), 0);

        // stall: five A transfers into a four-deep FIFO
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 16'h2000 | 16'(i), 16'h0000, 0);
            step(0, 16'(i), 16'h0000, 0);
            chk("st_hold", inst_data, 32'h2000_0000);
        end
        chk("st_ovf", 32'(ovf_a), 1);
        for (int k = 1; k < 4; k++) begin
            step(0, 16'h0000, 16'h0000, 1);
            w = {16'h2000 | 16'(k), 16'(k)};
            chk("st_order", inst_data, w);
        end
        step(0, 16'h0000, 16'h0000, 1);
        chk("st_drain", 32'(inst_valid), 0);
        chk("st_ovf_sticky", 32'(ovf_a), 1);

        // fairness with two entries each
        do_reset();
        for (int i = 0; i < 2; i++) begin
            step(1, 16'h4000 | 16'(i), 16'h6000 | 16'(i), 0);
            step(0, 16'h0011, 16'h0022, 0);
        end
        for (int k = 0; k < 4; k++) begin
            chk("fair_client", 32'(inst_client), 32'(k % 2));
            step(0, 16'h0000, 16'h0000, 1);
        end
        chk("fair_empty", 32'(inst_valid), 0);

        // reset while in LOW drops the partial instruction
        step(1, 16'h2200, 16'h3300, 0);
        chk("rl_busy", 32'(busy), 1);
        reset = 0;
        model_reset();
        #2;
        chk("rl_busy0", 32'(busy), 0);
        chk("rl_valid0", 32'(inst_valid), 0);
        chk("rl_ovf", 32'(ovf_a), 0);
        reset = 1;
        step(0, 16'h0055, 16'h0066, 0);
        step(0, 16'h0000, 16'h0000, 0);
        chk("rl_nopush", 32'(inst_valid), 0);

        // reserved opcode
        do_reset();
        step(1, 16'h8000, 16'h0000, 0);
        step(0, 16'h1234, 16'h0000, 0);
`ifdef ATS21_OPCODE_FILTER_EN
        chk("flt_valid", 32'(inst_valid), 0);
        chk("flt_ill", 32'(illegal), 1);
`else
        chk("flt_data", inst_data, 32'h8000_1234);
        chk("flt_ill", 32'(illegal), 0);
`endif

        // random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n % 700 == 699) do_reset();
            step($urandom_range(0, 2) == 0,
                 16'($urandom), 16'($urandom),
                 $urandom_range(0, 9) < 4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ats21_cmd_capture.md
Name: ats21_cmd_capture

Overview:
Front-end stage directly upstream of the ATS21 core. It captures two-cycle, 16-bit-per-cycle instruction transfers from client A (ctrlA) and client B (ctrlB) and reassembles each into a 32-bit instruction. Each client's instructions are buffered in a per-client FIFO. Buffered instructions are issued to the core one at a time over a valid/ready handshake, with round-robin arbitration between the clients.

Parameters:
FIFO_DEPTH, 4, entries per client FIFO; power of 2, minimum 2
INST_W, 32, assembled instruction width; fixed at 2x16

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req  input  1  transfer start strobe; high in the cycle that carries the upper halves
ctrlA  input  16  client A half-word; [31:16] in the req cycle, [15:0] in the next cycle
ctrlB  input  16  client B half-word; same timing as ctrlA
inst_valid  output  1  an assembled instruction is presented to the core
inst_data  output  32  assembled instruction {upper, lower}
inst_client  output  1  source of inst_data: 0 = A, 1 = B
inst_ready  input  1  core accepts inst_data this cycle
busy  output  1  capture FSM is in LOW
ovf_a  output  1  sticky: a client A instruction was dropped because its FIFO was full
ovf_b  output  1  sticky: a client B instruction was dropped because its FIFO was full
illegal  output  1  sticky: reserved opcode dropped (ATS21_OPCODE_FILTER_EN builds only; tied 0 otherwise)

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE; both FIFOs empty; arbitration pointer set to A. All outputs 0: inst_valid, inst_data, inst_client, busy, ovf_a, ovf_b, illegal.
- FSM, IDLE state:
  - On a clk edge with req=1, register hiA=ctrlA and hiB=ctrlB.
  - Set actA = (ctrlA[15:13] != 3'b000) and actB = (ctrlB[15:13] != 3'b000).
  - If actA or actB is set, go to LOW. Otherwise stay in IDLE; an all-NOP request is discarded.
- FSM, LOW state:
  - On the next edge, form {hiA, ctrlA} and {hiB, ctrlB}.
  - Push each active client's word into its own FIFO, then return to IDLE.
  - req is ignored while in LOW. There is no back-to-back overlap.
  - busy = 1 exactly while in LOW.
- A and B are independent. Either client, or both, may be active in one transfer. Both words are pushed on the same edge.
- Push when FIFO full: if the same FIFO is popped on that edge, the push is accepted. Otherwise the word is dropped and ovf_x is set to 1; ovf_x stays set until reset.
- Output mux is combinational from the FIFO heads:
  - inst_valid = (A non-empty) or (B non-empty).
  - Only one FIFO non-empty: present that FIFO's head.
  - Both non-empty: present the head selected by the pointer. After each accepted transfer (inst_valid & inst_ready), the pointer moves to the other client.
- Pop on inst_valid & inst_ready.
  - inst_data and inst_client must stay stable while inst_valid=1 and inst_ready=0.
  - The arbitration choice cannot change while the core stalls; the pointer updates only on acceptance.
- Latency: req at edge N, lower half at edge N+1, inst_valid=1 after edge N+1 (FIFO previously empty). This is 2 cycles from req to valid.
- FIFO pointers: log2(FIFO_DEPTH)+1 bits each. They wrap modulo 2*FIFO_DEPTH; the MSB distinguishes full from empty.
- inst_data holds its last value when inst_valid=0; the value is a don't-care for the core.
- Reset asserted mid-transfer (while in LOW) discards the partial instruction. Reset does not produce a push.

Optional Feature:
Macro ATS21_OPCODE_FILTER_EN.
- Defined: in LOW, an active word with opcode [31:29]=3'b100 (reserved) is not pushed, and illegal is set (sticky). The other client's word from the same transfer is handled normally.
- Undefined: opcode 100 words are pushed like any other instruction, and illegal is tied to 0.

Test Plan:
- Single A transfer: req with ctrlA=16'h2200/16'h0000, ctrlB=0 -> after edge N+1: inst_valid=1, inst_data=32'h22000000, inst_client=0; pop with inst_ready=1; no B word is created.
- Dual transfer: ctrlA=A025/0025, ctrlB=B700/0025, inst_ready=1 -> A000_? issued first: 32'hA0250025 (client 0), then 32'hB7000025 (client 1) the next cycle.
- Stall: fill A with 5 transfers while inst_ready=0 and FIFO_DEPTH=4 -> 4 entries held, ovf_a=1, inst_data stable at the first word; release -> 4 words in order, then inst_valid=0.
- Fairness: both FIFOs hold 2 entries, inst_ready=1 -> client order A, B, A, B.
- Reset mid-LOW: assert reset after the req cycle -> no push, inst_valid=0, busy=0, flags cleared.
- Filter: with ATS21_OPCODE_FILTER_EN, ctrlA=16'h8000/16'h1234 -> no push, illegal=1; without the macro -> 32'h80001234 is issued.
